// File: rtl/bcd_display_scan_pkg.sv
// Shared definitions for the multiplexed BCD display scanner.
// Contents: the segment bit order, the segment patterns for 0..9 and for
// the error glyph "E", the scan state enumeration, and a BCD validity helper.
package bcd_display_scan_pkg;

   // Segment vector bit order is {g,f,e,d,c,b,a}, so a is bit 0 and g is bit 6
   localparam int SEG_W = 7;
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [SEG_W-1:0] SEG_0   = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_1   = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_2   = 7'b1011011;
   localparam logic [SEG_W-1:0] SEG_3   = 7'b1001111;
   localparam logic [SEG_W-1:0] SEG_4   = 7'b1100110;
   localparam logic [SEG_W-1:0] SEG_5   = 7'b1101101;
   localparam logic [SEG_W-1:0] SEG_6   = 7'b1111101;
   localparam logic [SEG_W-1:0] SEG_7   = 7'b0000111;
   localparam logic [SEG_W-1:0] SEG_8   = 7'b1111111;
   localparam logic [SEG_W-1:0] SEG_9   = 7'b1101111;
   localparam logic [SEG_W-1:0] SEG_ERR = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_OFF = 7'b0000000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DEAD = 2'd1,
      ST_ON   = 2'd2
   } scan_state_e;

   // A BCD nibble is invalid when it encodes 10..15
   function automatic logic bcd_invalid(input logic [3:0] d);
      return (d > 4'd9);
   endfunction

endpackage

// File: rtl/bcd_display_scan_if.sv
// Bus between the decade counter chain / controller and the display scanner.
// master: drives bcd, dp, latch, en; reads seg, dpo, an, err.
// slave : the scanner; reads the counter-side signals, drives the display.
interface bcd_display_scan_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] bcd;     // digit i = bcd[4i+3:4i], digit 0 least significant
   logic [DIGITS-1:0]   dp;      // decimal point request per digit
   logic                latch;   // capture bcd/dp into the holding register
   logic                en;      // scan enable
   logic [6:0]          seg;     // {g,f,e,d,c,b,a}, active high
   logic                dpo;     // decimal point segment, active high
   logic [DIGITS-1:0]   an;      // one-hot digit select, all zero when dark
   logic                err;     // displayed snapshot holds a digit > 9

   modport master (
      output bcd, dp, latch, en,
      input  seg, dpo, an, err
   );

   modport slave (
      input  bcd, dp, latch, en,
      output seg, dpo, an, err
   );
endinterface

// File: rtl/bcd_display_scan_bcd7seg.sv
// bcd7seg: combinational BCD to 7-segment decoder.
// bcd     in  4  BCD code
// seg     out 7  {g,f,e,d,c,b,a}, active high; codes 10..15 show "E"
// invalid out 1  code is above 9
module bcd7seg
   import bcd_display_scan_pkg::*;
(
   input  logic [3:0]       bcd,
   output logic [SEG_W-1:0] seg,
   output logic             invalid
);

   // Pattern lookup; every non-decimal code falls through to the error glyph
   always_comb begin
      seg = SEG_ERR;
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_ERR;
      endcase
   end

   assign invalid = bcd_invalid(bcd);

endmodule

// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexed common-cathode 7-segment driver.
// Snapshots the counter digits on latch, swaps the snapshot into the
// displayed register only at frame start (no tearing), scans one digit per
// PRESCALE-cycle slot with DEAD dark cycles at the start of each slot,
// optionally blanks leading zeros and flags invalid digits.
// CLK  in   clock, rising edge
// CDN  in   asynchronous active-low reset
// bus  slave modport: bcd, dp, latch, en in; seg, dpo, an, err out
module bcd_display_scan
   import bcd_display_scan_pkg::*;
#(
   parameter int DIGITS   = 4,
   parameter int PRESCALE = 1000,
   parameter int DEAD     = 16,
   parameter int BLANK_LZ = 1
)(
   input  logic                 CLK,
   input  logic                 CDN,
   bcd_display_scan_if.slave    bus
);

   localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int DIG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   // Snapshot and displayed registers
   logic [4*DIGITS-1:0]           hold_bcd_r;
   logic [DIGITS-1:0]             hold_dp_r;
   logic                          pend_r;
   logic [4*DIGITS-1:0]           disp_bcd_r;
   logic [DIGITS-1:0]             disp_dp_r;
   logic [DIGITS-1:0][SEG_W-1:0]  disp_seg_r;
   logic                          err_r;

   // Scan state
   scan_state_e                   state_r;
   logic [CNT_W-1:0]              cnt_r;     // cycle within the current slot
   logic [DIG_W-1:0]              digit_r;

   // Registered display outputs
   logic [SEG_W-1:0]              seg_r;
   logic                          dpo_r;
   logic [DIGITS-1:0]             an_r;

   logic [DIGITS-1:0][SEG_W-1:0]  hold_seg_s;
   logic [DIGITS-1:0]             hold_inv_s;
   logic [DIGITS-1:0]             blank_s;
   logic                          frame_start_s;
   logic                          lz_run_s;

   // Decode the snapshot once per digit so the displayed patterns and the
   // error flag move into the display registers together with the digits
   for (genvar g = 0; g < DIGITS; g++) begin : g_dec
      bcd7seg u_dec (
         .bcd     (hold_bcd_r[4*g +: 4]),
         .seg     (hold_seg_s[g]),
         .invalid (hold_inv_s[g])
      );
   end

   // Leading-zero mask: walk down from the top digit while digits are zero
   // without a decimal point; digit 0 is never blanked
   always_comb begin
      blank_s  = '0;
      lz_run_s = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if ((disp_bcd_r[4*i +: 4] != 4'd0) || disp_dp_r[i]) begin
            lz_run_s = 1'b0;
         end else begin
            lz_run_s = lz_run_s;
         end
         blank_s[i] = lz_run_s && (BLANK_LZ != 0);
      end
   end

   // Frame start: entering DEAD for digit 0, either from IDLE or after the
   // last digit's ON period
   always_comb begin
      frame_start_s = 1'b0;
      if (!bus.en) begin
         frame_start_s = 1'b0;
      end else if (state_r == ST_IDLE) begin
         frame_start_s = 1'b1;
      end else if ((state_r == ST_ON) &&
                   (cnt_r == CNT_W'(PRESCALE - 1)) &&
                   (digit_r == DIG_W'(DIGITS - 1))) begin
         frame_start_s = 1'b1;
      end else begin
         frame_start_s = 1'b0;
      end
   end

   // Snapshot capture and frame-synchronous transfer into the display.
   // A latch on the frame-start cycle lands in hold while disp takes the
   // previous hold, so pend stays set for the following frame.
   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         hold_bcd_r <= '0;
         hold_dp_r  <= '0;
         pend_r     <= 1'b0;
         disp_bcd_r <= '0;
         disp_dp_r  <= '0;
         disp_seg_r <= {DIGITS{SEG_0}};
         err_r      <= 1'b0;
      end else begin
         if (frame_start_s && pend_r) begin
            disp_bcd_r <= hold_bcd_r;
            disp_dp_r  <= hold_dp_r;
            disp_seg_r <= hold_seg_s;
            err_r      <= |hold_inv_s;
         end
         if (bus.latch) begin
            hold_bcd_r <= bus.bcd;
            hold_dp_r  <= bus.dp;
            pend_r     <= 1'b1;
         end else if (frame_start_s) begin
            pend_r     <= 1'b0;
         end
      end
   end

   // Scan FSM with registered outputs; outputs reflect the state held
   // before this edge, and dropping en darkens the display at once
   always_ff @(posedge CLK or negedge CDN) begin
      if (!CDN) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         digit_r <= '0;
         seg_r   <= SEG_OFF;
         dpo_r   <= 1'b0;
         an_r    <= '0;
      end else if (!bus.en) begin
         state_r <= ST_IDLE;
         cnt_r   <= '0;
         digit_r <= '0;
         seg_r   <= SEG_OFF;
         dpo_r   <= 1'b0;
         an_r    <= '0;
      end else begin
         if ((state_r == ST_ON) && !blank_s[digit_r]) begin
            seg_r <= disp_seg_r[digit_r];
            dpo_r <= disp_dp_r[digit_r];
            an_r  <= {{(DIGITS-1){1'b0}}, 1'b1} << digit_r;
         end else begin
            seg_r <= SEG_OFF;
            dpo_r <= 1'b0;
            an_r  <= '0;
         end

         case (state_r)
            ST_IDLE: begin
               state_r <= ST_DEAD;
               cnt_r   <= '0;
               digit_r <= '0;
            end
            ST_DEAD: begin
               if (cnt_r == CNT_W'(DEAD - 1)) begin
                  state_r <= ST_ON;
               end
               cnt_r <= cnt_r + CNT_W'(1);
            end
            ST_ON: begin
               if (cnt_r == CNT_W'(PRESCALE - 1)) begin
                  state_r <= ST_DEAD;
                  cnt_r   <= '0;
                  if (digit_r == DIG_W'(DIGITS - 1)) begin
                     digit_r <= '0;
                  end else begin
                     digit_r <= digit_r + DIG_W'(1);
                  end
               end else begin
                  cnt_r <= cnt_r + CNT_W'(1);
               end
            end
            default: begin
               state_r <= ST_IDLE;
               cnt_r   <= '0;
               digit_r <= '0;
            end
         endcase
      end
   end

   assign bus.seg = seg_r;
   assign bus.dpo = dpo_r;
   assign bus.an  = an_r;
   assign bus.err = err_r;

endmodule

// File: tb/tb_bcd_display_scan.sv
// Self-checking bench for bcd_display_scan (DIGITS=4, PRESCALE=8, DEAD=2,
// BLANK_LZ=1). A frame-position model predicts every output on every cycle;
// directed sequences pin the model with literal expectations; then random
// stimulus runs against the model.
module tb_bcd_display_scan;

   localparam int DIGITS   = 4;
   localparam int PRESCALE = 8;
   localparam int DEAD     = 2;
   localparam int FRAME    = DIGITS * PRESCALE;

   logic CLK = 1'b0;
   logic CDN = 1'b0;
   always #5 CLK = ~CLK;

   bcd_display_scan_if #(.DIGITS(DIGITS)) bus ();

   bcd_display_scan #(
      .DIGITS   (DIGITS),
      .PRESCALE (PRESCALE),
      .DEAD     (DEAD),
      .BLANK_LZ (1)
   ) dut (
      .CLK (CLK),
      .CDN (CDN),
      .bus (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [6:0] pattern(input logic [3:0] v);
      case (v)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b1111001;
      endcase
   endfunction

   // Model state: position within the frame counted from frame start
   bit          m_active;
   int          m_pos;
   logic [15:0] m_disp, m_hold;
   logic [3:0]  m_disp_dp, m_hold_dp;
   bit          m_pend, m_err;

   function automatic bit is_blank(input int s);
      if (s == 0) return 1'b0;
      for (int j = s; j < DIGITS; j++) begin
         if (m_disp[4*j +: 4] != 4'd0 || m_disp_dp[j]) return 1'b0;
      end
      return 1'b1;
   endfunction

   function automatic bit any_bad(input logic [15:0] v);
      for (int j = 0; j < DIGITS; j++) begin
         if (v[4*j +: 4] > 4'd9) return 1'b1;
      end
      return 1'b0;
   endfunction

   logic        en_m, lat_m;
   logic [15:0] bcd_m;
   logic [3:0]  dp_m;
   logic [3:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dpo;
   int          slot, off;
   bit          fs;

   // Per-cycle compare against the frame-position model
   always @(posedge CLK) begin
      en_m  = bus.en;
      lat_m = bus.latch;
      bcd_m = bus.bcd;
      dp_m  = bus.dp;
      e_an  = 4'd0;
      e_seg = 7'd0;
      e_dpo = 1'b0;
      if (!CDN) begin
         m_active = 1'b0; m_pos = 0; m_disp = 16'd0; m_hold = 16'd0;
         m_disp_dp = 4'd0; m_hold_dp = 4'd0; m_pend = 1'b0; m_err = 1'b0;
      end else begin
         if (en_m && m_active) begin
            slot = m_pos / PRESCALE;
            off  = m_pos % PRESCALE;
            if (off >= DEAD && !is_blank(slot)) begin
               e_an  = 4'd1 << slot;
               e_seg = pattern(m_disp[4*slot +: 4]);
               e_dpo = m_disp_dp[slot];
            end
         end
         fs = en_m && (!m_active || m_pos == FRAME - 1);
         if (!en_m) begin
            m_active = 1'b0; m_pos = 0;
         end else if (!m_active) begin
            m_active = 1'b1; m_pos = 0;
         end else begin
            m_pos = (m_pos + 1) % FRAME;
         end
         if (fs && m_pend) begin
            m_disp = m_hold; m_disp_dp = m_hold_dp; m_pend = 1'b0;
            m_err = any_bad(m_hold);
         end
         if (lat_m) begin
            m_hold = bcd_m; m_hold_dp = dp_m; m_pend = 1'b1;
         end
      end
      #1;
      check("an",  bus.an,  e_an);
      check("seg", bus.seg, e_seg);
      check("dpo", bus.dpo, e_dpo);
      check("err", bus.err, m_err);
   end

   task automatic wait_an(input logic [3:0] tgt, input string name);
      int n = 0;
      while (bus.an !== tgt && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check(name, bus.an, tgt);
   endtask

   task automatic wait_err(input logic tgt, input string name);
      int n = 0;
      while (bus.err !== tgt && n < 200) begin
         @(negedge CLK);
         n++;
      end
      check(name, bus.err, tgt);
   endtask

   task automatic do_latch(input logic [15:0] b, input logic [3:0] d);
      bus.bcd = b; bus.dp = d; bus.latch = 1'b1;
      @(negedge CLK);
      bus.latch = 1'b0;
   endtask

   initial begin
      int hits;
      bus.bcd = 16'd0; bus.dp = 4'd0; bus.latch = 1'b0; bus.en = 1'b1;
      repeat (3) @(negedge CLK);
      check("rst_an",  bus.an,  4'd0);
      check("rst_seg", bus.seg, 7'd0);
      check("rst_err", bus.err, 1'b0);
      CDN = 1'b1;
      // edges 0..2 dark, digit 0 lit from edge 3 through edge 8
      repeat (3) @(negedge CLK);
      check("first_dark", bus.an, 4'd0);
      @(negedge CLK);
      check("first_an",  bus.an,  4'b0001);
      check("first_seg", bus.seg, 7'b0111111);
      repeat (5) @(negedge CLK);
      check("an_held6", bus.an, 4'b0001);
      @(negedge CLK);
      check("an_off", bus.an, 4'd0);

      do_latch(16'h1234, 4'd0);
      wait_an(4'b1000, "wait_d3");
      check("d3_seg", bus.seg, 7'b0000110);
      wait_an(4'b0100, "wait_d2");
      check("d2_seg", bus.seg, 7'b1011011);
      wait_an(4'b0010, "wait_d1");
      check("d1_seg", bus.seg, 7'b1001111);
      wait_an(4'b0001, "wait_d0");
      check("d0_seg", bus.seg, 7'b1100110);

      do_latch(16'h00A5, 4'd0);
      wait_err(1'b1, "err_set");
      wait_an(4'b0010, "wait_e");
      check("e_seg", bus.seg, 7'b1111001);
      do_latch(16'h0005, 4'd0);
      wait_err(1'b0, "err_clr");

      do_latch(16'h0070, 4'd0);
      wait_an(4'b0010, "wait_7");
      check("seg_7", bus.seg, 7'b0000111);
      hits = 0;
      repeat (2 * FRAME) begin
         @(negedge CLK);
         if (bus.an[3] || bus.an[2]) hits++;
      end
      check("lz_blank", hits, 0);

      do_latch(16'h0070, 4'b1000);
      wait_an(4'b1000, "wait_dp3");
      check("dp3_seg", bus.seg, 7'b0111111);
      check("dp3_dpo", bus.dpo, 1'b1);
      wait_an(4'b0100, "wait_z2");
      check("z2_seg", bus.seg, 7'b0111111);
      check("z2_dpo", bus.dpo, 1'b0);

      bus.en = 1'b0;
      @(negedge CLK);
      check("en_drop", bus.an, 4'd0);
      repeat (3) @(negedge CLK);
      bus.en = 1'b1;
      repeat (3) @(negedge CLK);
      check("restart_dark", bus.an, 4'd0);
      @(negedge CLK);
      check("restart_d0", bus.an, 4'b0001);

      // Randomized phase with one mid-scan reset
      for (int c = 0; c < 1500; c++) begin
         @(negedge CLK);
         bus.en    = ($urandom_range(31, 0) != 0);
         bus.latch = ($urandom_range(3, 0) == 0);
         for (int i = 0; i < DIGITS; i++) begin
            if ($urandom_range(1, 0) == 0) bus.bcd[4*i +: 4] = 4'd0;
            else bus.bcd[4*i +: 4] = 4'($urandom_range(15, 0));
            bus.dp[i] = ($urandom_range(5, 0) == 0);
         end
         if (c == 700) CDN = 1'b0;
         if (c == 703) CDN = 1'b1;
      end
      @(negedge CLK);
      @(negedge CLK);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
